// File: rtl/lut_pkg.sv
// Shared types and constants for the programmable lookup-table engine.
package lut_pkg;

    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lut_table.sv
// Flip-flop truth-table storage: one synchronous write port, combinational read.
module lut_table #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] RST_TABLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [N_IN-1:0]  waddr,
    input  logic [N_OUT-1:0] wdata,
    input  logic [N_IN-1:0]  raddr,
    output logic [N_OUT-1:0] rdata
);

    logic [(2**N_IN)*N_OUT-1:0] tbl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q <= RST_TABLE;
        end else if (we) begin
            tbl_q[int'(waddr)*N_OUT +: N_OUT] <= wdata;
        end
    end

    assign rdata = tbl_q[int'(raddr)*N_OUT +: N_OUT];

endmodule

// File: rtl/lut_engine.sv
// Configurable LUT evaluator: load the table in CFG, stream vectors through it in RUN,
// and empty the single-entry output register in DRAIN before returning to CFG.
module lut_engine
    import lut_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] RST_TABLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_data,
    input  logic             cfg_commit,
    input  logic             cfg_unlock,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    output logic             state_run,
    output logic             cfg_err,
    output logic [15:0]      eval_cnt
);

    state_e           state_q;
    logic             out_valid_q;
    logic [N_OUT-1:0] out_data_q;
    logic             cfg_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_OUT-1:0] lut_rdata;
    logic             xfer;
    logic             out_hs;
    logic             tbl_we;

    // An unlock request closes the input in the same cycle so nothing new enters the output register.
    assign in_ready = (state_q == ST_RUN) && !cfg_unlock && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign tbl_we   = cfg_we && (state_q == ST_CFG);

    lut_table #(
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .RST_TABLE (RST_TABLE)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (in_data),
        .rdata (lut_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CFG;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_CFG:   if (cfg_commit) state_q <= ST_RUN;
                ST_RUN:   if (cfg_unlock) state_q <= (!out_valid_q || out_ready) ? ST_CFG : ST_DRAIN;
                ST_DRAIN: if (out_ready)  state_q <= ST_CFG;
                default:  state_q <= ST_CFG;
            endcase

            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= lut_rdata;
                cnt_q       <= sat_inc(cnt_q);
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end

            if (cfg_we && (state_q != ST_CFG)) cfg_err_q <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign state_run = (state_q == ST_RUN);
    assign cfg_err   = cfg_err_q;
    assign eval_cnt  = cnt_q;

endmodule

// File: tb/tb_lut_engine.sv
// Directed bench for lut_engine with N_IN=3, N_OUT=1, RST_TABLE=8'h30.
module tb_lut_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we, cfg_commit, cfg_unlock;
    logic [2:0] cfg_addr;
    logic [0:0] cfg_data;
    logic       in_valid, in_ready;
    logic [2:0] in_data;
    logic       out_valid, out_ready;
    logic [0:0] out_data;
    logic       state_run, cfg_err;
    logic [15:0] eval_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_cnt = 0;

    lut_engine #(.N_IN(3), .N_OUT(1), .RST_TABLE(8'h30)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_unlock(cfg_unlock), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .state_run(state_run), .cfg_err(cfg_err), .eval_cnt(eval_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 0; cfg_commit = 0; cfg_unlock = 0; cfg_addr = 0; cfg_data = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else pass_cnt++;
        total_cnt++; if (state_run !== 1'b0) $display("FAIL rst_state_run: got %b expected 0", state_run); else pass_cnt++;
        total_cnt++; if (eval_cnt !== 16'h0) $display("FAIL rst_eval_cnt: got %0h expected 0", eval_cnt); else pass_cnt++;
        step(); step();
        rst_n = 1'b1;
        step();
        total_cnt++; if (state_run !== 1'b0 || cfg_err !== 1'b0) $display("FAIL post_rst_state: run=%b err=%b expected 0 0", state_run, cfg_err); else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [7:0] exp_tbl;
        exp_tbl = 8'h30;
        cfg_commit = 1;
        step();
        cfg_commit = 0;
        total_cnt++; if (state_run !== 1'b1) $display("FAIL sweep_commit: state_run=%b expected 1", state_run); else pass_cnt++;
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = 3'(i);
            #1;
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL sweep_in_ready[%0d]: got %b expected 1", i, in_ready); else pass_cnt++;
            step();
            exp_cnt++;
            total_cnt++;
            if (out_valid !== 1'b1 || out_data[0] !== exp_tbl[i])
                $display("FAIL sweep_out[%0d]: valid=%b data=%b expected 1 %b", i, out_valid, out_data, exp_tbl[i]);
            else pass_cnt++;
        end
        in_valid = 0;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL sweep_drain: out_valid=%b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (eval_cnt !== 16'd8) $display("FAIL sweep_eval_cnt: got %0d expected 8", eval_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1; in_data = 3'b100; out_ready = 1;
        step(); exp_cnt++;
        in_data = 3'b011; out_ready = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready); else pass_cnt++;
            step();
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== 1'b1) $display("FAIL bp_hold[%0d]: valid=%b data=%b expected 1 1", k, out_valid, out_data);
            else pass_cnt++;
        end
        out_ready = 1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", in_ready); else pass_cnt++;
        step(); exp_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 1'b0) $display("FAIL b2b_first: valid=%b data=%b expected 1 0", out_valid, out_data); else pass_cnt++;
        in_data = 3'b101;
        step(); exp_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 1'b1) $display("FAIL b2b_second: valid=%b data=%b expected 1 1", out_valid, out_data); else pass_cnt++;
        in_valid = 0;
        step();
        total_cnt++; if (eval_cnt !== 16'(exp_cnt)) $display("FAIL b2b_eval_cnt: got %0d expected %0d", eval_cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_cfg_err();
        cfg_we = 1; cfg_addr = 0; cfg_data = 1;
        step();
        cfg_we = 0;
        total_cnt++; if (cfg_err !== 1'b1) $display("FAIL err_set: cfg_err=%b expected 1", cfg_err); else pass_cnt++;
        in_valid = 1; in_data = 0; out_ready = 1;
        step(); exp_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 1'b0) $display("FAIL err_tbl0: valid=%b data=%b expected 1 0", out_valid, out_data); else pass_cnt++;
        in_valid = 0;
        step();
    endtask

    task automatic test_drain();
        in_valid = 1; in_data = 3'b100; out_ready = 1;
        step(); exp_cnt++;
        in_valid = 0; out_ready = 0; cfg_unlock = 1;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL unlock_in_ready: got %b expected 0", in_ready); else pass_cnt++;
        step();
        cfg_unlock = 0; cfg_commit = 1;
        total_cnt++; if (state_run !== 1'b0 || out_valid !== 1'b1) $display("FAIL drain_enter: run=%b valid=%b expected 0 1", state_run, out_valid); else pass_cnt++;
        step();
        cfg_commit = 0;
        total_cnt++; if (state_run !== 1'b0 || out_valid !== 1'b1 || out_data !== 1'b1) $display("FAIL drain_hold: run=%b valid=%b data=%b expected 0 1 1", state_run, out_valid, out_data); else pass_cnt++;
        out_ready = 1;
        step();
        total_cnt++; if (state_run !== 1'b0 || out_valid !== 1'b0) $display("FAIL drain_exit: run=%b valid=%b expected 0 0", state_run, out_valid); else pass_cnt++;
        cfg_we = 1; cfg_addr = 3'b111; cfg_data = 1;
        step();
        cfg_we = 0; cfg_commit = 1; cfg_unlock = 1;
        step();
        cfg_commit = 0; cfg_unlock = 0;
        total_cnt++; if (state_run !== 1'b1) $display("FAIL recommit: state_run=%b expected 1", state_run); else pass_cnt++;
        in_valid = 1; in_data = 3'b111;
        step(); exp_cnt++;
        total_cnt++; if (out_data !== 1'b1) $display("FAIL entry7: got %b expected 1", out_data); else pass_cnt++;
        in_data = 3'b101;
        step(); exp_cnt++;
        total_cnt++; if (out_data !== 1'b1) $display("FAIL persist5: got %b expected 1", out_data); else pass_cnt++;
        in_valid = 0;
        step();
        total_cnt++; if (cfg_err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", cfg_err); else pass_cnt++;
    endtask

    task automatic test_saturation();
        int n;
        n = 16'hFFFE - exp_cnt;
        in_valid = 1; in_data = 0; out_ready = 1;
        repeat (n) step();
        in_valid = 0;
        step();
        total_cnt++; if (eval_cnt !== 16'hFFFE) $display("FAIL sat_fffe: got %0h expected fffe", eval_cnt); else pass_cnt++;
        in_valid = 1;
        step();
        step();
        total_cnt++; if (eval_cnt !== 16'hFFFF) $display("FAIL sat_ffff: got %0h expected ffff", eval_cnt); else pass_cnt++;
        step();
        in_valid = 0;
        step();
        total_cnt++; if (eval_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %0h expected ffff", eval_cnt); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        in_valid = 1; in_data = 3'b100; out_ready = 1;
        step();
        in_valid = 0; out_ready = 0;
        step();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL ar_pre: out_valid=%b expected 1", out_valid); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || state_run !== 1'b0 || out_data !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL ar_immediate: valid=%b run=%b data=%b ready=%b expected 0 0 0 0", out_valid, state_run, out_data, in_ready);
        else pass_cnt++;
        total_cnt++; if (eval_cnt !== 16'h0 || cfg_err !== 1'b0) $display("FAIL ar_regs: cnt=%0h err=%b expected 0 0", eval_cnt, cfg_err); else pass_cnt++;
        #3 rst_n = 1'b1;
        in_valid = 1; out_ready = 1;
        step();
        total_cnt++; if (out_valid !== 1'b0 || eval_cnt !== 16'h0) $display("FAIL ar_no_xfer: valid=%b cnt=%0h expected 0 0", out_valid, eval_cnt); else pass_cnt++;
        in_valid = 0; cfg_commit = 1;
        step();
        cfg_commit = 0;
        in_valid = 1; in_data = 3'b111;
        step();
        total_cnt++; if (out_data !== 1'b0) $display("FAIL ar_table7: got %b expected 0", out_data); else pass_cnt++;
        in_data = 3'b100;
        step();
        total_cnt++; if (out_data !== 1'b1) $display("FAIL ar_table4: got %b expected 1", out_data); else pass_cnt++;
        in_valid = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_back_to_back();
        test_cfg_err();
        test_drain();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
